// File: rtl/mul_hilo_ctrl_pkg.sv
// rtl/mul_hilo_ctrl_pkg.sv - shared CPU types and constants for the HI/LO multiply stage
package mul_hilo_ctrl_pkg;

  // Datapath word width; the product is twice this.
  localparam int WIDTH = 32;

  // Hold counter width; wide enough for MUL_CYCLES up to 15.
  localparam int CNT_W = 4;

  // Read-port select values for rd_sel.
  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

  // Multiply sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - multicycle operand hold, HI/LO product capture and direct HI/LO access
module mul_hilo_ctrl
  import mul_hilo_ctrl_pkg::*;
#(
  parameter int WIDTH      = mul_hilo_ctrl_pkg::WIDTH,
  parameter int MUL_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   x_in,
  input  logic [WIDTH-1:0]   y_in,
  output logic [WIDTH-1:0]   op_x,
  output logic [WIDTH-1:0]   op_y,
  input  logic [2*WIDTH-1:0] prod_in,
  input  logic               hi_wr,
  input  logic               lo_wr,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               rd_sel,
  output logic [WIDTH-1:0]   data_out,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               done
);

  // The multiplier is a multicycle path: operands sit still for MUL_CYCLES
  // edges, and the counter reaching zero marks the edge that samples prod_in.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             load_ops;
  logic             capture;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the load/capture strobes and status outputs.
  always_comb begin
    next_state = state;
    load_ops   = 1'b0;
    capture    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_ops   = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        // start is deliberately ignored here: no queueing of a second multiply.
        busy = 1'b1;
        if (cnt == '0) begin
          capture    = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load_ops   = 1'b1;
          next_state = WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Operand registers and hold counter; operands only change on a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_x <= '0;
      op_y <= '0;
      cnt  <= '0;
    end else if (load_ops) begin
      op_x <= x_in;
      op_y <= y_in;
      cnt  <= CNT_LOAD;
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // HI/LO pair: a product capture overrides any direct write on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (capture) begin
      hi <= prod_in[2*WIDTH-1:WIDTH];
      lo <= prod_in[WIDTH-1:0];
    end else begin
      if (hi_wr) hi <= data_in;
      if (lo_wr) lo <= data_in;
    end
  end

  // Read port shows the registered value; a write in flight is not bypassed.
  always_comb begin
    data_out = (rd_sel == SEL_HI) ? hi : lo;
  end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb/tb_mul_hilo_ctrl.sv - directed self-checking bench for mul_hilo_ctrl with a behavioural multiplier
module tb_mul_hilo_ctrl;
  import mul_hilo_ctrl_pkg::*;

  localparam int W  = 32;
  localparam int MC = 2;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   x_in;
  logic [W-1:0]   y_in;
  logic [W-1:0]   op_x;
  logic [W-1:0]   op_y;
  logic [2*W-1:0] prod_in;
  logic           hi_wr;
  logic           lo_wr;
  logic [W-1:0]   data_in;
  logic           rd_sel;
  logic [W-1:0]   data_out;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           busy;
  logic           done;

  int passed;
  int total;

  mul_hilo_ctrl #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x_in     (x_in),
    .y_in     (y_in),
    .op_x     (op_x),
    .op_y     (op_y),
    .prod_in  (prod_in),
    .hi_wr    (hi_wr),
    .lo_wr    (lo_wr),
    .data_in  (data_in),
    .rd_sel   (rd_sel),
    .data_out (data_out),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done)
  );

  // Stand-in for the combinational signed multiplier: low 2W bits of the
  // product of sign-extended operands equal the signed product.
  assign prod_in = {{W{op_x[W-1]}}, op_x} * {{W{op_y[W-1]}}, op_y};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    x_in  = x;
    y_in  = y;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 20) begin
      tick();
      edges++;
    end
    if (!done) edges = 99;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (hi !== 32'h0) $display("FAIL reset_hi got %h exp %h", hi, 32'h0); else passed++;
    total++; if (lo !== 32'h0) $display("FAIL reset_lo got %h exp %h", lo, 32'h0); else passed++;
    total++; if ({op_x, op_y} !== 64'h0) $display("FAIL reset_ops got %h exp %h", {op_x, op_y}, 64'h0); else passed++;
    total++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got %b exp %b", {busy, done}, 2'b00); else passed++;
    total++; if (dut.state !== IDLE) $display("FAIL reset_state got %0d exp %0d", dut.state, IDLE); else passed++;
  endtask

  task automatic test_basic();
    start_op(32'd7, 32'hFFFFFFFD);
    total++; if (op_x !== 32'd7 || op_y !== 32'hFFFFFFFD) $display("FAIL basic_ops got %h/%h exp %h/%h", op_x, op_y, 32'd7, 32'hFFFFFFFD); else passed++;
    total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL basic_busy1 got %b%b exp 10", busy, done); else passed++;
    tick();
    total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL basic_busy2 got %b%b exp 10", busy, done); else passed++;
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b1) $display("FAIL basic_done got %b%b exp 01", busy, done); else passed++;
    total++; if (hi !== 32'hFFFFFFFF) $display("FAIL basic_hi got %h exp %h", hi, 32'hFFFFFFFF); else passed++;
    total++; if (lo !== 32'hFFFFFFEB) $display("FAIL basic_lo got %h exp %h", lo, 32'hFFFFFFEB); else passed++;
    tick();
    total++; if (done !== 1'b0) $display("FAIL basic_done_pulse got %b exp 0", done); else passed++;
  endtask

  task automatic test_corner();
    int e;
    start_op(32'h80000000, 32'h80000000);
    wait_done(e);
    total++; if (e !== MC) $display("FAIL corner_min_latency got %0d exp %0d", e, MC); else passed++;
    total++; if ({hi, lo} !== 64'h40000000_00000000) $display("FAIL corner_min got %h exp %h", {hi, lo}, 64'h40000000_00000000); else passed++;
    tick();
    start_op(32'h7FFFFFFF, 32'h80000000);
    wait_done(e);
    total++; if ({hi, lo} !== 64'hC0000000_80000000) $display("FAIL corner_maxmin got %h exp %h", {hi, lo}, 64'hC0000000_80000000); else passed++;
    tick();
  endtask

  task automatic test_start_while_busy();
    int e;
    int pulses;
    start_op(32'd5, 32'd6);
    start_op(32'd9, 32'd9);
    total++; if (op_x !== 32'd5 || op_y !== 32'd6) $display("FAIL busy_ops_held got %0d/%0d exp 5/6", op_x, op_y); else passed++;
    wait_done(e);
    total++; if (e !== 1) $display("FAIL busy_latency got %0d exp 1", e); else passed++;
    total++; if ({hi, lo} !== 64'd30) $display("FAIL busy_result got %h exp %h", {hi, lo}, 64'd30); else passed++;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) pulses++;
    end
    total++; if (pulses !== 0) $display("FAIL busy_extra_done got %0d exp 0", pulses); else passed++;
  endtask

  task automatic test_back_to_back();
    int e;
    start_op(32'd2, 32'd3);
    wait_done(e);
    total++; if (lo !== 32'd6) $display("FAIL b2b_first_lo got %0d exp 6", lo); else passed++;
    start_op(32'd4, 32'd5);
    total++; if (busy !== 1'b1 || op_x !== 32'd4) $display("FAIL b2b_reload got busy=%b op_x=%0d exp busy=1 op_x=4", busy, op_x); else passed++;
    wait_done(e);
    total++; if (e + 1 !== MC + 1) $display("FAIL b2b_spacing got %0d exp %0d", e + 1, MC + 1); else passed++;
    total++; if (lo !== 32'd20 || hi !== 32'd0) $display("FAIL b2b_second got %h_%h exp %h_%h", hi, lo, 32'd0, 32'd20); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    int e;
    int pulses;
    start_op(32'd100, 32'd100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (dut.state !== IDLE || busy !== 1'b0) $display("FAIL rstmid_state got %0d busy=%b exp %0d busy=0", dut.state, busy, IDLE); else passed++;
    total++; if ({hi, lo, op_x, op_y} !== 128'h0) $display("FAIL rstmid_regs got %h exp 0", {hi, lo, op_x, op_y}); else passed++;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) pulses++;
      tick();
    end
    total++; if (pulses !== 0) $display("FAIL rstmid_done got %0d exp 0", pulses); else passed++;
    start_op(32'd1, 32'd1);
    wait_done(e);
    total++; if ({hi, lo} !== 64'd1) $display("FAIL rstmid_after got %h exp %h", {hi, lo}, 64'd1); else passed++;
    tick();
  endtask

  task automatic test_direct_rw();
    hi_wr   = 1'b1;
    data_in = 32'hCAFEF00D;
    tick();
    hi_wr   = 1'b0;
    lo_wr   = 1'b1;
    data_in = 32'hDEADBEEF;
    rd_sel  = SEL_LO;
    #1;
    total++; if (data_out !== 32'd1) $display("FAIL rw_no_bypass got %h exp %h", data_out, 32'd1); else passed++;
    tick();
    lo_wr = 1'b0;
    #1;
    total++; if (data_out !== 32'hDEADBEEF) $display("FAIL rw_read_lo got %h exp %h", data_out, 32'hDEADBEEF); else passed++;
    rd_sel = SEL_HI;
    #1;
    total++; if (data_out !== 32'hCAFEF00D) $display("FAIL rw_read_hi got %h exp %h", data_out, 32'hCAFEF00D); else passed++;
    hi_wr   = 1'b1;
    lo_wr   = 1'b1;
    data_in = 32'h11112222;
    tick();
    hi_wr = 1'b0;
    lo_wr = 1'b0;
    total++; if ({hi, lo} !== 64'h11112222_11112222) $display("FAIL rw_both got %h exp %h", {hi, lo}, 64'h11112222_11112222); else passed++;
  endtask

  task automatic test_capture_wins();
    start_op(32'd3, 32'd3);
    tick();
    hi_wr   = 1'b1;
    lo_wr   = 1'b1;
    data_in = 32'h1234;
    tick();
    hi_wr = 1'b0;
    lo_wr = 1'b0;
    total++; if (done !== 1'b1) $display("FAIL capwin_done got %b exp 1", done); else passed++;
    total++; if (hi !== 32'd0 || lo !== 32'd9) $display("FAIL capwin_hilo got %h_%h exp %h_%h", hi, lo, 32'd0, 32'd9); else passed++;
    tick();
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    rst     = 1'b0;
    start   = 1'b0;
    x_in    = '0;
    y_in    = '0;
    hi_wr   = 1'b0;
    lo_wr   = 1'b0;
    data_in = '0;
    rd_sel  = SEL_LO;
    #2;
    test_reset();
    test_basic();
    test_corner();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_direct_rw();
    test_capture_wins();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
